mul32_shift_add: RTL

- Unsigned 32x32 -> 64-bit sequential shift-add multiplier.
- Sits downstream of the team's 32-bit carry-lookahead adder `cla32_ov` and consumes its sum and carry-out on every iteration step.
- One add-and-shift per clock, 32 iterations, with a start/done/clear handshake.
- Used by the ALU datapath for multiply operations.

---
 rtl/mul32_pkg.sv | 16 +
 rtl/cla32_ov.sv | 39 +++
 rtl/mul32_shift_add.sv | 103 ++++++++++
 3 files changed

// File: rtl/mul32_pkg.sv
// Shared constants and state encoding for the 32x32 shift-add multiplier.
package mul32_pkg;

    localparam int DATA_W = 32;
    localparam int ITER_N = DATA_W;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cla32_ov.sv
// 32-bit adder built from 4-bit carry-lookahead groups; exposes carry-out and
// the carry into bit 31 for overflow detection by signed users.
module cla32_ov (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co,
    output logic        co_prev
);

    logic [3:0] gen_v;
    logic [3:0] prop_v;
    logic [3:0] c;
    logic       carry;

    always_comb begin
        carry   = ci;
        s       = '0;
        co_prev = 1'b0;
        gen_v   = '0;
        prop_v  = '0;
        c       = '0;
        for (int g = 0; g < 8; g++) begin
            gen_v  = a[g*4 +: 4] & b[g*4 +: 4];
            prop_v = a[g*4 +: 4] ^ b[g*4 +: 4];
            c[0] = carry;
            c[1] = gen_v[0] | (prop_v[0] & carry);
            c[2] = gen_v[1] | (prop_v[1] & gen_v[0]) | ((&prop_v[1:0]) & carry);
            c[3] = gen_v[2] | (prop_v[2] & gen_v[1]) | ((&prop_v[2:1]) & gen_v[0])
                 | ((&prop_v[2:0]) & carry);
            s[g*4 +: 4] = prop_v ^ c;
            if (g == 7) co_prev = c[3];
            carry = gen_v[3] | (prop_v[3] & c[3]);
        end
        co = carry;
    end

endmodule

// File: rtl/mul32_shift_add.sv
// Unsigned 32x32->64 sequential multiplier: one add-and-shift per clock using
// cla32_ov, 32 iterations, start/done/clear handshake.
module mul32_shift_add
    import mul32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    input  logic                  op_clear,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic                  op_busy,
    output logic                  op_done,
    output logic [2*DATA_W-1:0]   result
);

    // Handshake: op_start is taken only in IDLE; op_clear wins over op_start and
    // aborts from any state; result is meaningful only while op_done is high.
    state_t            state;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] m_reg;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] addend;
    logic [DATA_W-1:0] sum;
    logic              carry_out;
    logic              unused_co_prev;

    assign addend = q_reg[0] ? m_reg : '0;

    cla32_ov u_add (
        .a       (a_reg),
        .b       (addend),
        .ci      (1'b0),
        .s       (sum),
        .co      (carry_out),
        .co_prev (unused_co_prev)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_clear) begin
                        a_reg <= '0;
                        q_reg <= '0;
                        m_reg <= '0;
                        count <= '0;
                    end else if (op_start) begin
                        a_reg <= '0;
                        q_reg <= multiplier;
                        m_reg <= multiplicand;
                        count <= '0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_clear) begin
                        a_reg <= '0;
                        q_reg <= '0;
                        m_reg <= '0;
                        count <= '0;
                        state <= ST_IDLE;
                    end else begin
                        // Carry-out becomes the MSB of A so no product bit is lost.
                        a_reg <= {carry_out, sum[DATA_W-1:1]};
                        q_reg <= {sum[0], q_reg[DATA_W-1:1]};
                        count <= count + CNT_W'(1);
                        if (count == LAST_CNT) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (op_clear) begin
                        a_reg <= '0;
                        q_reg <= '0;
                        m_reg <= '0;
                        count <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    a_reg <= '0;
                    q_reg <= '0;
                    m_reg <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_busy = (state == ST_EXEC);
    assign op_done = (state == ST_DONE);
    assign result  = (state == ST_DONE) ? {a_reg, q_reg} : '0;

endmodule
